// File: rtl/shift_unit_arbiter_pkg.sv
// Shared definitions for the shift-unit arbiter: data width, op and state encodings,
// and the single-stage shift primitive used by the barrel shifter.
package shift_unit_arbiter_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } arb_state_e;

    // Rotate by DATA_W is the identity, since d >> DATA_W is zero and d << 0 is d.
    function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] d,
                                                     input shift_op_e         op,
                                                     input int unsigned       k);
        logic [DATA_W-1:0] r;
        case (op)
            OP_SLL:  r = d << k;
            OP_SRL:  r = d >> k;
            OP_SRA:  r = DATA_W'($signed(d) >>> k);
            default: r = (d >> k) | (d << (DATA_W - k));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_shifter.sv
// Shared combinational 8-bit shift unit. data2 carries {op, 2'b00, amt}; amt is not
// clamped, so bit 3 contributes a full 8-position shift on top of amt[2:0].
module shift_unit_arbiter_shifter
    import shift_unit_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] result
);

    shift_op_e         op;
    logic [3:0]        amt;
    logic [DATA_W-1:0] s8, s4, s2;
    logic              unused_pad;

    assign op         = shift_op_e'(data2[7:6]);
    assign amt        = data2[3:0];
    assign unused_pad = ^data2[5:4];

    always_comb begin
        s8     = amt[3] ? shift_step(data1, op, 8) : data1;
        s4     = amt[2] ? shift_step(s8, op, 4)    : s8;
        s2     = amt[1] ? shift_step(s4, op, 2)    : s4;
        result = amt[0] ? shift_step(s2, op, 1)    : s2;
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one shift unit between two valid/ready requesters, with
// operand and result registers and a programmable settle time in EXEC.
//
//   state | meaning
//   IDLE  | waiting for a request; READY driven to the granted requester
//   EXEC  | operands held on the shift unit; counting down settle cycles
//   DONE  | result presented on the response channel until RSP_READY
module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_op,
    input  logic [3:0]        req0_amt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_op,
    input  logic [3:0]        req1_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam logic [2:0] CNT_LOAD = 3'(SETTLE_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic              rr_ptr_q;
    logic              owner_q;
    logic [DATA_W-1:0] data_q;
    shift_op_e         op_q;
    logic [3:0]        amt_q;
    logic [2:0]        cnt_q;
    logic              grant, grant_valid;
    logic              accept, capture;
    logic [DATA_W-1:0] shift_result;

    shift_unit_arbiter_shifter u_shift (
        .data1  (data_q),
        .data2  ({op_q, 2'b00, amt_q}),
        .result (shift_result)
    );

    // Preferred requester is rr_ptr; the other one gets the slot only if rr_ptr is idle.
    always_comb begin
        grant       = rr_ptr_q;
        grant_valid = 1'b0;
        if (rr_ptr_q ? req1_valid : req0_valid) begin
            grant       = rr_ptr_q;
            grant_valid = 1'b1;
        end else if (rr_ptr_q ? req0_valid : req1_valid) begin
            grant       = ~rr_ptr_q;
            grant_valid = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    accept     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            data_q    <= '0;
            op_q      <= OP_SLL;
            amt_q     <= '0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q  <= grant;
                rr_ptr_q <= ~grant;
                data_q   <= grant ? req1_data : req0_data;
                op_q     <= shift_op_e'(grant ? req1_op : req0_op);
                amt_q    <= grant ? req1_amt : req0_amt;
                cnt_q    <= CNT_LOAD;
            end else if (state_q == ST_EXEC && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_id    <= owner_q;
                rsp_data  <= shift_result;
            end else if (state_q == ST_DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: per-requester expected-result queues filled at
// accept time, drained by a monitor on every response handshake.
module tb_shift_unit_arbiter;
    import shift_unit_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_amt, req1_amt;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [7:0] b_req0_data, b_req1_data;
    logic [1:0] b_req0_op, b_req1_op;
    logic [3:0] b_req0_amt, b_req1_amt;
    logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;
    logic [7:0] b_rsp_data;

    shift_unit_arbiter #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_op(req0_op), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_op(req1_op), .req1_amt(req1_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    shift_unit_arbiter #(.SETTLE_CYCLES(3)) dut_s3 (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_data(b_req0_data),
        .req0_op(b_req0_op), .req0_amt(b_req0_amt),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_data(b_req1_data),
        .req1_op(b_req1_op), .req1_amt(b_req1_amt),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data), .busy(b_busy)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         grant_log[$];
    int         rsp_log[$];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: grant exclusivity, grant/response order logs, scoreboard pops.
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_exclusive", int'(req0_ready & req1_ready), 0);
            if (req0_valid && req0_ready) grant_log.push_back(0);
            if (req1_valid && req1_ready) grant_log.push_back(1);
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id));
                if ((rsp_id ? exp_q1.size() : exp_q0.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected no response",
                             rsp_id, rsp_data);
                end else if (rsp_id) begin
                    check("rsp_data_req1", int'(rsp_data), int'(exp_q1.pop_front()));
                end else begin
                    check("rsp_data_req0", int'(rsp_data), int'(exp_q0.pop_front()));
                end
            end
        end
    end

    task automatic issue(input int n, input logic [7:0] d, input logic [1:0] op,
                         input logic [3:0] amt, input logic [7:0] expv, input bit track);
        bit got = 1'b0;
        if (n == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_op = op; req0_amt = amt;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_op = op; req1_amt = amt;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (n == 0 ? req0_ready : req1_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: req%0d got no ready expected ready within 60 cycles", n);
        end else if (track) begin
            if (n == 0) exp_q0.push_back(expv);
            else exp_q1.push_back(expv);
        end
        @(posedge clk); #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int i = 0;
        while (i < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0 || busy)) begin
            @(posedge clk); #1;
            i++;
        end
        check("drain_timeout", int'(i == 100), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        {req0_valid, req1_valid} = '0;
        {req0_data, req0_op, req0_amt, req1_data, req1_op, req1_amt} = '0;
        {b_req0_valid, b_req1_valid} = '0;
        {b_req0_data, b_req0_op, b_req0_amt, b_req1_data, b_req1_op, b_req1_amt} = '0;
        rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_req0_ready", int'(req0_ready), 0);
        check("rst_req1_ready", int'(req1_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_busy", int'(busy), 0);

        // Basic op and accept-to-valid latency.
        issue(0, 8'h0F, OP_SLL, 4'd2, 8'h3C, 1'b1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_s1", lat, 2);
        wait_drain();
        check("t1_rsp_id", rsp_log.size() > 0 ? rsp_log[rsp_log.size()-1] : -1, 0);

        // Op coverage, including unclamped amounts above 8.
        issue(1, 8'hB4, OP_ROR, 4'd3,  8'h96, 1'b1);
        issue(0, 8'h80, OP_SRA, 4'd7,  8'hFF, 1'b1);
        issue(0, 8'h80, OP_SRL, 4'd3,  8'h10, 1'b1);
        issue(0, 8'h80, OP_SRA, 4'd9,  8'hFF, 1'b1);
        issue(1, 8'h81, OP_ROR, 4'd9,  8'hC0, 1'b1);
        issue(1, 8'h01, OP_SLL, 4'd15, 8'h00, 1'b1);
        issue(0, 8'hF0, OP_SRL, 4'd12, 8'h00, 1'b1);
        wait_drain();

        // Fairness with both requesters holding VALID.
        pulse_reset();
        grant_log.delete();
        rsp_log.delete();
        fork
            begin
                issue(0, 8'h11, OP_SLL, 4'd1, 8'h22, 1'b1);
                issue(0, 8'h11, OP_SLL, 4'd2, 8'h44, 1'b1);
            end
            begin
                issue(1, 8'hF0, OP_SRL, 4'd4, 8'h0F, 1'b1);
                issue(1, 8'hF0, OP_SRA, 4'd4, 8'hFF, 1'b1);
            end
        join
        wait_drain();
        check("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rr_grant_order", grant_log[i], i % 2);
        end
        check("rr_rsp_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("rr_rsp_order", rsp_log[i], i % 2);
        end

        // Response stall in DONE with another request pending.
        rsp_ready = 1'b0;
        issue(0, 8'h3C, OP_ROR, 4'd4, 8'hC3, 1'b1);
        req1_valid = 1'b1; req1_data = 8'h0F; req1_op = OP_SLL; req1_amt = 4'd4;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_data", int'(rsp_data), 8'hC3);
            check("stall_rsp_id", int'(rsp_id), 0);
            check("stall_busy", int'(busy), 1);
            check("stall_no_ready", int'(req0_ready | req1_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_idle", int'(busy), 0);
        check("release_rsp_valid", int'(rsp_valid), 0);
        issue(1, 8'h0F, OP_SLL, 4'd4, 8'hF0, 1'b1);
        wait_drain();

        // Reset during EXEC: in-flight op dropped, rr_ptr back to 0.
        issue(0, 8'h55, OP_SLL, 4'd1, 8'h00, 1'b0);
        check("pre_reset_busy", int'(busy), 1);
        pulse_reset();
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_rsp_data", int'(rsp_data), 0);
        check("abort_rsp_id", int'(rsp_id), 0);
        check("abort_busy", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        grant_log.delete();
        fork
            issue(0, 8'h01, OP_SLL, 4'd3, 8'h08, 1'b1);
            issue(1, 8'h80, OP_SRL, 4'd7, 8'h01, 1'b1);
        join
        wait_drain();
        check("post_reset_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // SETTLE_CYCLES=3 instance: latency and shift by 8.
        b_req0_valid = 1'b1; b_req0_data = 8'h01; b_req0_op = OP_SLL; b_req0_amt = 4'd8;
        lat = 0;
        while (!b_req0_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("s3_accept_timeout", int'(lat == 20), 0);
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        lat = 1;
        while (!b_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_s3", lat, 4);
        check("s3_rsp_data", int'(b_rsp_data), 8'h00);
        check("s3_rsp_id", int'(b_rsp_id), 0);
        @(posedge clk); #1;
        check("s3_release_idle", int'(b_busy), 0);

        check("scoreboard_empty", exp_q0.size() + exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish expected finish before 500000");
        $fatal(1);
    end

endmodule
